// File: rtl/keypad_pkg.sv
// Shared types, key codes and decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StEmit,
        StWaitRel
    } state_e;

    localparam logic [3:0] KEY_A         = 4'd10;
    localparam logic [3:0] KEY_B         = 4'd11;
    localparam logic [3:0] KEY_C         = 4'd12;
    localparam logic [3:0] KEY_D         = 4'd13;
    localparam logic [3:0] KEY_STAR      = 4'd14;
    localparam logic [3:0] KEY_HASH      = 4'd15;
    localparam logic [3:0] KEY_CMD_LOCK  = 4'd9;
    localparam logic [3:0] KEY_CMD_REPRO = 4'd8;
    localparam logic [3:0] KEY_CANCEL    = 4'd7;

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = KEY_A;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = KEY_B;
            4'h8:    code = KEY_CANCEL;
            4'h9:    code = KEY_CMD_REPRO;
            4'hA:    code = KEY_CMD_LOCK;
            4'hB:    code = KEY_C;
            4'hC:    code = KEY_STAR;
            4'hD:    code = 4'd0;
            4'hE:    code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Ghosting and multi-key presses show up as more than one low row.
    function automatic logic single_low(input logic [3:0] rows);
        logic one;
        case (rows)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: one = 1'b1;
            default:                            one = 1'b0;
        endcase
        return one;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles at all-high.
module keypad_row_sync (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] rows_n,
    output logic [3:0] rs
);

    logic [3:0] meta_q;
    logic [3:0] rs_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta_q <= 4'b1111;
            rs_q   <= 4'b1111;
        end else begin
            meta_q <= rows_n;
            rs_q   <= meta_q;
        end
    end

    assign rs = rs_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, debounce, one rdy pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] rows_n,
    output logic [3:0] col_n,
    output logic [3:0] keypress,
    output logic       rdy,
    output logic       key_held
);

    localparam int unsigned DwellW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]   DebLast   = DebW'(DEBOUNCE - 1);

    logic [3:0] rs;

    keypad_row_sync u_row_sync (
        .clk    (clk),
        .resetN (resetN),
        .rows_n (rows_n),
        .rs     (rs)
    );

    state_e            state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [1:0]        row_idx_q, row_idx_d;
    logic [3:0]        pattern_q, pattern_d;
    logic [3:0]        col_n_q, col_n_d;
    logic [3:0]        keypress_q, keypress_d;
    logic              rdy_q, rdy_d;
    logic              key_held_q, key_held_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StScan;
            dwell_q    <= '0;
            deb_q      <= '0;
            col_idx_q  <= 2'd0;
            row_idx_q  <= 2'd0;
            pattern_q  <= 4'b1111;
            col_n_q    <= 4'b1110;
            keypress_q <= 4'd0;
            rdy_q      <= 1'b0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            deb_q      <= deb_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            pattern_q  <= pattern_d;
            col_n_q    <= col_n_d;
            keypress_q <= keypress_d;
            rdy_q      <= rdy_d;
            key_held_q <= key_held_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        deb_d      = deb_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        pattern_d  = pattern_q;
        col_n_d    = col_n_q;
        keypress_d = keypress_q;
        rdy_d      = 1'b0;
        key_held_d = key_held_q;

        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (single_low(rs)) begin
                        // Column stays frozen while the candidate key is debounced.
                        row_idx_d = low_index(rs);
                        pattern_d = rs;
                        deb_d     = '0;
                        state_d   = StDebounce;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                        col_n_d   = col_drive(col_idx_q + 2'd1);
                    end
                end else begin
                    dwell_d = dwell_q + DwellW'(1);
                end
            end

            StDebounce: begin
                if (rs == pattern_q) begin
                    if (deb_q == DebLast) begin
                        keypress_d = key_map(row_idx_q, col_idx_q);
                        rdy_d      = 1'b1;
                        key_held_d = 1'b1;
                        deb_d      = '0;
                        state_d    = StEmit;
                    end else begin
                        deb_d = deb_q + DebW'(1);
                    end
                end else begin
                    dwell_d = '0;
                    state_d = StScan;
                end
            end

            StEmit: begin
                deb_d   = '0;
                state_d = StWaitRel;
            end

            StWaitRel: begin
                // Any low row, including a different key, restarts the release count.
                if (rs == 4'b1111) begin
                    if (deb_q == DebLast) begin
                        key_held_d = 1'b0;
                        deb_d      = '0;
                        dwell_d    = '0;
                        col_idx_d  = col_idx_q + 2'd1;
                        col_n_d    = col_drive(col_idx_q + 2'd1);
                        state_d    = StScan;
                    end else begin
                        deb_d = deb_q + DebW'(1);
                    end
                end else begin
                    deb_d = '0;
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase
    end

    assign col_n    = col_n_q;
    assign keypress = keypress_q;
    assign rdy      = rdy_q;
    assign key_held = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 8;
    localparam int LAT_MAX = 2 + 4 * SCAN_DIV + DEBOUNCE + 1;

    logic       clk = 1'b0;
    logic       resetN;
    logic [3:0] rows_n;
    logic [3:0] col_n;
    logic [3:0] keypress;
    logic       rdy;
    logic       key_held;

    logic [15:0] pressed;
    int          checks = 0;
    int          failures = 0;
    int          rdy_seen = 0;
    logic [3:0]  exp_q[$];
    int          key_code [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    always #5 clk = ~clk;

    // Row r is pulled low iff a pressed key sits at (r, driven column).
    always_comb begin
        rows_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_n[c] == 1'b0 && pressed[r * 4 + c]) rows_n[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .rows_n   (rows_n),
        .col_n    (col_n),
        .keypress (keypress),
        .rdy      (rdy),
        .key_held (key_held)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int r, input int c, input logic v);
        pressed[r * 4 + c] = v;
    endtask

    task automatic expect_key(input int r, input int c);
        exp_q.push_back(4'(key_code[r * 4 + c]));
    endtask

    task automatic wait_rdy(input string name, input int budget, output int took);
        took = 0;
        while (exp_q.size() != 0 && took < budget) begin
            @(negedge clk);
            #1;
            took++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s: no rdy within %0d cycles, %0d expected press(es) pending",
                     name, budget, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pops the scoreboard on every rdy and polices rdy width / keypress stability.
    initial begin
        logic [3:0] kp_prev;
        logic       rdy_prev;
        logic       armed;
        logic [3:0] e;
        armed = 1'b0;
        kp_prev = '0;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (resetN !== 1'b1) begin
                armed = 1'b0;
            end else begin
                if (rdy === 1'b1) begin
                    rdy_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rdy: keypress=%0d with no press expected",
                                 keypress);
                    end else begin
                        e = exp_q.pop_front();
                        if (keypress !== e) begin
                            failures++;
                            $display("FAIL rdy_keypress: got %0d expected %0d", keypress, e);
                        end
                    end
                    if (armed && rdy_prev === 1'b1) begin
                        checks++;
                        failures++;
                        $display("FAIL rdy_width: rdy high on two consecutive cycles");
                    end
                end else if (armed) begin
                    checks++;
                    if (keypress !== kp_prev) begin
                        failures++;
                        $display("FAIL keypress_stable: got %0d expected %0d (no rdy)",
                                 keypress, kp_prev);
                    end
                end
                armed = 1'b1;
            end
            kp_prev = keypress;
            rdy_prev = rdy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int took;
        int base;
        int k;
        pressed = '0;
        resetN = 1'b0;
        cycles(3);
        check("reset_col_n", col_n, 4'b1110);
        check("reset_keypress", keypress, 0);
        check("reset_rdy", rdy, 0);
        check("reset_key_held", key_held, 0);
        resetN = 1'b1;
        cycles(5);

        // '9' held long: one pulse, release timing of key_held.
        base = rdy_seen;
        set_key(2, 2, 1'b1);
        expect_key(2, 2);
        wait_rdy("press_9", LAT_MAX, took);
        check("held_9_key_held", key_held, 1);
        cycles(200);
        check("held_9_single_rdy", rdy_seen - base, 1);
        check("held_9_keypress", keypress, 9);
        check("held_9_still_held", key_held, 1);
        set_key(2, 2, 1'b0);
        cycles(DEBOUNCE);
        check("release_9_not_yet", key_held, 1);
        cycles(3);
        check("release_9_done", key_held, 0);
        cycles(5);

        // '*' then '#'.
        set_key(3, 0, 1'b1);
        expect_key(3, 0);
        wait_rdy("press_star", LAT_MAX, took);
        set_key(3, 0, 1'b0);
        cycles(20);
        check("between_keypress", keypress, 14);
        check("between_key_held", key_held, 0);
        set_key(3, 2, 1'b1);
        expect_key(3, 2);
        wait_rdy("press_hash", LAT_MAX, took);
        check("hash_keypress", keypress, 15);
        set_key(3, 2, 1'b0);
        cycles(20);

        // Bouncing '8', then stable.
        base = rdy_seen;
        for (int i = 0; i < 14; i++) begin
            pressed[9] = ~pressed[9];
            cycles(3);
        end
        check("bounce_no_rdy", rdy_seen - base, 0);
        set_key(2, 1, 1'b1);
        expect_key(2, 1);
        wait_rdy("bounce_8_latency", LAT_MAX, took);
        set_key(2, 1, 1'b0);
        cycles(20);

        // '7' and '4' together in column 0: rejected until '4' lets go.
        base = rdy_seen;
        set_key(2, 0, 1'b1);
        set_key(1, 0, 1'b1);
        cycles(100);
        check("multi_key_no_rdy", rdy_seen - base, 0);
        set_key(1, 0, 1'b0);
        expect_key(2, 0);
        wait_rdy("press_7_after_4", LAT_MAX, took);
        set_key(2, 0, 1'b0);
        cycles(20);

        // '0' held, '5' added during WAIT_REL.
        set_key(3, 1, 1'b1);
        expect_key(3, 1);
        wait_rdy("press_0", LAT_MAX, took);
        base = rdy_seen;
        set_key(1, 1, 1'b1);
        cycles(60);
        set_key(3, 1, 1'b0);
        cycles(60);
        check("second_key_no_rdy", rdy_seen - base, 0);
        check("second_key_held", key_held, 1);
        set_key(1, 1, 1'b0);
        cycles(DEBOUNCE + 3);
        check("all_released_key_held", key_held, 0);
        set_key(1, 1, 1'b1);
        expect_key(1, 1);
        wait_rdy("press_5_fresh", LAT_MAX, took);
        set_key(1, 1, 1'b0);
        cycles(20);

        // Async reset with a prior code held, then reset mid-debounce of '3'.
        resetN = 1'b0;
        #1;
        check("async_rst_keypress", keypress, 0);
        check("async_rst_col_n", col_n, 4'b1110);
        check("async_rst_key_held", key_held, 0);
        cycles(2);
        resetN = 1'b1;
        set_key(0, 2, 1'b1);
        cycles(15);
        resetN = 1'b0;
        #1;
        check("mid_deb_rst_col_n", col_n, 4'b1110);
        check("mid_deb_rst_rdy", rdy, 0);
        check("mid_deb_rst_keypress", keypress, 0);
        check("mid_deb_rst_key_held", key_held, 0);
        cycles(3);
        resetN = 1'b1;
        expect_key(0, 2);
        wait_rdy("press_3_after_reset", LAT_MAX, took);
        check("fresh_debounce_latency", took, 3 * SCAN_DIV + DEBOUNCE);
        set_key(0, 2, 1'b0);
        cycles(20);

        // Random presses, optionally bounced, random hold times.
        for (int n = 0; n < 12; n++) begin
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 2 * int'($urandom_range(1, 4)); i++) begin
                    pressed[k] = ~pressed[k];
                    cycles(int'($urandom_range(1, 3)));
                end
            end
            pressed[k] = 1'b1;
            expect_key(k / 4, k % 4);
            wait_rdy("rand_press", LAT_MAX, took);
            cycles(int'($urandom_range(10, 80)));
            check("rand_keypress", keypress, key_code[k]);
            check("rand_key_held", key_held, 1);
            pressed[k] = 1'b0;
            cycles(DEBOUNCE + 3);
            check("rand_released", key_held, 0);
            cycles(int'($urandom_range(0, 10)));
        end

        cycles(20);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad and turns physical presses into the `keypress[3:0]` / `rdy` event stream consumed by the lock-control FSM.
- One debounced press produces exactly one single-cycle `rdy` pulse with a stable 4-bit code.
- Sits between the board keypad pins and the lock-control FSM (`keypress`, `rdy` inputs).

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (settle time, min 4).
- DEBOUNCE, 50000, consecutive stable cycles required to accept a press or a release (min 2).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- rows_n  in  4  keypad row inputs, active low (pulled up), asynchronous to clk.
- col_n  out  4  column drives, one-hot active low.
- keypress  out  4  code of the last accepted key; held until the next accept.
- rdy  out  1  one-cycle pulse, asserted when keypress is updated.
- key_held  out  1  high from the rdy cycle until the release is debounced.

Behaviour:
- Reset values (asynchronous, immediate on resetN low): col_n=4'b1110, keypress=0, rdy=0, key_held=0, state SCAN, all counters 0.
- Row synchronisation:
  - rows_n passes through a 2-flop synchronizer (rs).
  - All row decisions use rs only.
- Key map, (row, col) to code:
  - r0: 1, 2, 3, 10
  - r1: 4, 5, 6, 11
  - r2: 7, 8, 9, 12
  - r3: 14(*), 0, 15(#), 13
- Column drive: col_n = ~(1<<col_idx), registered, and only changed in SCAN.
- State SCAN:
  - The dwell counter counts 0..SCAN_DIV-1.
  - At the terminal count, rs is sampled.
  - Exactly one row low: latch row_idx and col_idx, clear the debounce counter, go to DEBOUNCE. The column stays frozen.
  - No row low, or more than one row low (ghost/multi-key reject): col_idx advances (3 wraps to 0), the dwell restarts, and the state stays SCAN.
- State DEBOUNCE:
  - Each cycle, rs must equal the sampled pattern.
  - If it matches, the counter increments.
  - If it differs, go to SCAN on the same column with the dwell restarted.
  - When the counter reaches DEBOUNCE-1 with a match, go to EMIT.
- State EMIT, lasting one cycle:
  - Registered outputs update on the entry edge: keypress=map(row, col), rdy=1, key_held=1.
  - The next state is WAIT_REL.
  - rdy is high for exactly this one cycle.
- State WAIT_REL:
  - rdy=0 and key_held=1.
  - The counter counts cycles with rs=4'b1111 and clears on any low row.
  - When DEBOUNCE consecutive all-high cycles are reached: key_held=0, col_idx advances, dwell restarts, go to SCAN.
  - No rdy is generated for presses while in WAIT_REL, including a second key or a re-bounce.
- Latency: a clean press stable from cycle t gives rdy within 2 (sync) + SCAN_DIV*4 (worst-case scan) + DEBOUNCE + 1 cycles.
- Held key: exactly one rdy, however long the key is held.
- keypress: never changes except on the rdy cycle.
- Reset mid-operation: everything returns to reset values; a partially debounced press is discarded and emits no rdy.
- Counter widths: $clog2 of the respective parameter, saturating is not needed.
- No combinational path from rows_n to any output.

Decomposition:
- Shared package keypad_pkg:
  - state enum (SCAN, DEBOUNCE, EMIT, WAIT_REL)
  - key code constants (KEY_STAR=14, KEY_HASH=15, KEY_A..KEY_D=10..13, KEY_CMD_LOCK=9, KEY_CMD_REPRO=8, KEY_CANCEL=7)
  - the 4x4 map function
- Sub-module: keypad_row_sync, a 4-bit 2-flop synchronizer with async active-low reset to 4'b1111.

Test Plan:
- Setup for all scenarios:
  - SCAN_DIV=4, DEBOUNCE=8.
  - The bench models the matrix: row r low iff a key at (r, active column) is pressed.
- Press '9' (r2, c2), clean, hold 200 cycles -> exactly one rdy pulse with keypress=9, key_held=1 until 8 cycles after release, then key_held=0.
- Press '*' then release, then press '#' -> two rdy pulses with keypress=14 then 15; keypress stays 14 between the pulses.
- Bounce '8' (r2, c1): toggle every 3 cycles for 40 cycles, then stable -> no rdy during bouncing; one rdy with keypress=8 within 2+16+8+1 cycles of going stable.
- Press '7' and '4' together (same column c0, rows 2 and 1) -> no rdy while both are held; release '4' -> one rdy with keypress=7.
- Hold '0' (r3, c1), and during WAIT_REL also press '5' -> no second rdy; only after all keys are released for 8 cycles can a new press generate rdy.
- Assert resetN low mid-DEBOUNCE of key '3' -> outputs immediately reset (col_n=1110, rdy=0, keypress=0, key_held=0); no rdy after reset release until a fresh full debounce.
